// File: rtl/axi_ram_responder.sv
// AXI4 subordinate backed by a byte-writable single-port RAM.
// One FSM serializes reads and writes; FIXED/INCR/WRAP bursts supported.
module axi_ram_responder #(
    parameter int ID_WIDTH   = 6,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int MEM_DEPTH  = 8192
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [ID_WIDTH-1:0]     i_awid,
    input  logic [ADDR_WIDTH-1:0]   i_awaddr,
    input  logic [7:0]              i_awlen,
    input  logic [2:0]              i_awsize,
    input  logic [1:0]              i_awburst,
    input  logic                    i_awvalid,
    output logic                    o_awready,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb,
    input  logic                    i_wlast,
    input  logic                    i_wvalid,
    output logic                    o_wready,
    output logic [ID_WIDTH-1:0]     o_bid,
    output logic [1:0]              o_bresp,
    output logic                    o_bvalid,
    input  logic                    i_bready,
    input  logic [ID_WIDTH-1:0]     i_arid,
    input  logic [ADDR_WIDTH-1:0]   i_araddr,
    input  logic [7:0]              i_arlen,
    input  logic [2:0]              i_arsize,
    input  logic [1:0]              i_arburst,
    input  logic                    i_arvalid,
    output logic                    o_arready,
    output logic [ID_WIDTH-1:0]     o_rid,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic [1:0]              o_rresp,
    output logic                    o_rlast,
    output logic                    o_rvalid,
    input  logic                    i_rready
);
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int NBYTES = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_e;

    state_e                state_q, state_d;
    logic                  active_q, active_d;
    logic                  last_rd_q, last_rd_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [2:0]            size_q, size_d;
    logic [1:0]            burst_q, burst_d;
    logic                  err_q, err_d;
    logic                  rd_done_q, rd_done_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  grant_w;
    logic                  ram_we;
    logic                  ram_re;
    logic                  last_beat;
    logic [IDX_W-1:0]      word_idx;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] wmask;
    logic [ADDR_WIDTH-1:0] incr;

    assign word_idx  = addr_q[IDX_W+2:3];
    assign last_beat = (cnt_q == len_q);
    assign grant_w   = i_awvalid & (~i_arvalid | last_rd_q);

    // WRAP keeps the bits above the (len+1)<<size container fixed
    always_comb begin
        step  = ADDR_WIDTH'(1) << size_q;
        wmask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q)
                - ADDR_WIDTH'(1);
        incr  = addr_q + step;
        case (burst_q)
            2'b00:   addr_nxt = addr_q;
            2'b10:   addr_nxt = (addr_q & ~wmask) | (incr & wmask);
            default: addr_nxt = incr;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        active_d  = 1'b1;
        last_rd_d = last_rd_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        size_d    = size_q;
        burst_d   = burst_q;
        err_d     = err_q;
        rd_done_d = rd_done_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        o_awready = 1'b0;
        o_arready = 1'b0;
        o_wready  = 1'b0;
        o_bvalid  = 1'b0;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        case (state_q)
            IDLE: begin
                o_awready = active_q & i_awvalid & grant_w;
                o_arready = active_q & i_arvalid & ~grant_w;
                if (o_awready) begin
                    id_d      = i_awid;
                    addr_d    = i_awaddr;
                    len_d     = i_awlen;
                    size_d    = i_awsize;
                    burst_d   = i_awburst;
                    cnt_d     = 8'd0;
                    err_d     = 1'b0;
                    last_rd_d = 1'b0;
                    state_d   = WRITE;
                end else if (o_arready) begin
                    id_d      = i_arid;
                    addr_d    = i_araddr;
                    len_d     = i_arlen;
                    size_d    = i_arsize;
                    burst_d   = i_arburst;
                    cnt_d     = 8'd0;
                    rd_done_d = 1'b0;
                    last_rd_d = 1'b1;
                    state_d   = READ;
                end
            end
            WRITE: begin
                o_wready = 1'b1;
                if (i_wvalid) begin
                    ram_we = 1'b1;
                    if (i_wlast != last_beat) err_d = 1'b1;
                    if (last_beat) begin
                        state_d = WRESP;
                    end else begin
                        cnt_d  = cnt_q + 8'd1;
                        addr_d = addr_nxt;
                    end
                end
            end
            WRESP: begin
                o_bvalid = 1'b1;
                if (i_bready) state_d = IDLE;
            end
            READ: begin
                if (rvalid_q && i_rready) begin
                    rvalid_d = 1'b0;
                    rlast_d  = 1'b0;
                    if (rlast_q) state_d = IDLE;
                end
                // the RAM output register doubles as the R skid: no
                // new read while the presented beat is stalled
                if (!rd_done_q && (!rvalid_q || i_rready)) begin
                    ram_re   = 1'b1;
                    rvalid_d = 1'b1;
                    rlast_d  = last_beat;
                    if (last_beat) begin
                        rd_done_d = 1'b1;
                    end else begin
                        cnt_d  = cnt_q + 8'd1;
                        addr_d = addr_nxt;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            active_q  <= 1'b0;
            last_rd_q <= 1'b0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            err_q     <= 1'b0;
            rd_done_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            last_rd_q <= last_rd_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            err_q     <= err_d;
            rd_done_q <= rd_done_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            if (ram_re) rdata_q <= mem[word_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (i_wstrb[b]) mem[word_idx][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    assign o_bid   = id_q;
    assign o_bresp = err_q ? 2'b10 : 2'b00;
    assign o_rid   = id_q;
    assign o_rdata = rdata_q;
    assign o_rresp = 2'b00;
    assign o_rlast = rlast_q;
    assign o_rvalid = rvalid_q;

endmodule

// File: tb/tb_axi_ram_responder.sv
// Randomized self-checking bench for axi_ram_responder against a
// word-array memory model with arithmetic burst address rules.
module tb_axi_ram_responder;
    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [5:0]  i_awid = '0;
    logic [31:0] i_awaddr = '0;
    logic [7:0]  i_awlen = '0;
    logic [2:0]  i_awsize = '0;
    logic [1:0]  i_awburst = '0;
    logic        i_awvalid = 1'b0;
    logic        o_awready;
    logic [63:0] i_wdata = '0;
    logic [7:0]  i_wstrb = '0;
    logic        i_wlast = 1'b0;
    logic        i_wvalid = 1'b0;
    logic        o_wready;
    logic [5:0]  o_bid;
    logic [1:0]  o_bresp;
    logic        o_bvalid;
    logic        i_bready = 1'b0;
    logic [5:0]  i_arid = '0;
    logic [31:0] i_araddr = '0;
    logic [7:0]  i_arlen = '0;
    logic [2:0]  i_arsize = '0;
    logic [1:0]  i_arburst = '0;
    logic        i_arvalid = 1'b0;
    logic        o_arready;
    logic [5:0]  o_rid;
    logic [63:0] o_rdata;
    logic [1:0]  o_rresp;
    logic        o_rlast;
    logic        o_rvalid;
    logic        i_rready = 1'b0;

    axi_ram_responder dut (
        .clk(clk), .rstn(rstn),
        .i_awid(i_awid), .i_awaddr(i_awaddr), .i_awlen(i_awlen),
        .i_awsize(i_awsize), .i_awburst(i_awburst),
        .i_awvalid(i_awvalid), .o_awready(o_awready),
        .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wlast(i_wlast),
        .i_wvalid(i_wvalid), .o_wready(o_wready),
        .o_bid(o_bid), .o_bresp(o_bresp), .o_bvalid(o_bvalid),
        .i_bready(i_bready),
        .i_arid(i_arid), .i_araddr(i_araddr), .i_arlen(i_arlen),
        .i_arsize(i_arsize), .i_arburst(i_arburst),
        .i_arvalid(i_arvalid), .o_arready(o_arready),
        .o_rid(o_rid), .o_rdata(o_rdata), .o_rresp(o_rresp),
        .o_rlast(o_rlast), .o_rvalid(o_rvalid), .i_rready(i_rready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    logic [63:0] mm [int];

    logic [63:0] rq_d [$];
    logic        rq_l [$];
    logic [5:0]  r_id;
    logic [1:0]  r_resp;
    int          r_first;
    int          r_holdbad;

    function automatic int beat_word(logic [31:0] a, int len, int sz,
                                     int bu, int k);
        longint bytes, cont, base, addr;
        bytes = longint'(1) << sz;
        if (bu == 0) begin
            addr = longint'(a);
        end else if (bu == 2) begin
            cont = longint'(len + 1) * bytes;
            base = (longint'(a) / cont) * cont;
            addr = base + ((longint'(a) - base + k * bytes) % cont);
        end else begin
            addr = longint'(a) + k * bytes;
        end
        return int'((addr >> 3) % 8192);
    endfunction

    function automatic void model_wr(int w, logic [63:0] d, logic [7:0] s);
        logic [63:0] cur;
        cur = mm.exists(w) ? mm[w] : 64'h0;
        for (int b = 0; b < 8; b++)
            if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
        mm[w] = cur;
    endfunction

    function automatic logic [63:0] model_rd(int w);
        return mm.exists(w) ? mm[w] : 64'h0;
    endfunction

    task automatic send_aw(input logic [5:0] id, input logic [31:0] a,
                           input int len, input int sz, input int bu,
                           output int waits);
        i_awid = id; i_awaddr = a; i_awlen = 8'(len);
        i_awsize = 3'(sz); i_awburst = 2'(bu); i_awvalid = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!o_awready && waits < 100) begin
            waits++;
            @(negedge clk);
        end
        @(posedge clk); #1;
        i_awvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [5:0] id, input logic [31:0] a,
                           input int len, input int sz, input int bu,
                           output int waits);
        i_arid = id; i_araddr = a; i_arlen = 8'(len);
        i_arsize = 3'(sz); i_arburst = 2'(bu); i_arvalid = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!o_arready && waits < 100) begin
            waits++;
            @(negedge clk);
        end
        @(posedge clk); #1;
        i_arvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] a, input int len, input int sz,
                          input int bu, input logic [63:0] dq [$],
                          input logic [7:0] strb, input int last_at,
                          output int waits);
        int n;
        waits = 0;
        for (int k = 0; k <= len; k++) begin
            i_wdata = dq[k]; i_wstrb = strb;
            i_wlast = (k == last_at); i_wvalid = 1'b1;
            n = 0;
            @(negedge clk);
            while (!o_wready && n < 100) begin
                n++; waits++;
                @(negedge clk);
            end
            @(posedge clk); #1;
            model_wr(beat_word(a, len, sz, bu, k), dq[k], strb);
        end
        i_wvalid = 1'b0; i_wlast = 1'b0;
    endtask

    task automatic get_b(output logic [5:0] id, output logic [1:0] resp,
                         output int waits);
        i_bready = 1'b1; waits = 0;
        @(negedge clk);
        while (!o_bvalid && waits < 100) begin
            waits++;
            @(negedge clk);
        end
        id = o_bid; resp = o_bresp;
        @(posedge clk); #1;
        i_bready = 1'b0;
    endtask

    task automatic write_burst(input logic [5:0] id, input logic [31:0] a,
                               input int len, input int sz, input int bu,
                               input logic [63:0] dq [$],
                               input logic [7:0] strb, input int last_at,
                               output logic [1:0] resp,
                               output logic [5:0] bid, output int waits);
        int w1, w2, w3;
        send_aw(id, a, len, sz, bu, w1);
        send_w(a, len, sz, bu, dq, strb, last_at, w2);
        get_b(bid, resp, w3);
        waits = w1 + w2 + w3;
    endtask

    task automatic get_r(input int nb, input bit stall);
        logic [63:0] pd;
        logic        pl;
        bit          held;
        int          cyc;
        rq_d.delete(); rq_l.delete();
        r_first = -1; r_holdbad = 0; r_resp = 2'b00;
        held = 1'b0; cyc = 0; pd = '0; pl = 1'b0;
        while (rq_d.size() < nb && cyc < 400) begin
            i_rready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            @(negedge clk);
            if (held && (o_rvalid !== 1'b1 || o_rdata !== pd ||
                         o_rlast !== pl))
                r_holdbad++;
            held = 1'b0;
            if (o_rvalid) begin
                if (r_first < 0) r_first = cyc;
                r_id = o_rid;
                r_resp = r_resp | o_rresp;
                if (i_rready) begin
                    rq_d.push_back(o_rdata);
                    rq_l.push_back(o_rlast);
                end else begin
                    held = 1'b1; pd = o_rdata; pl = o_rlast;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        i_rready = 1'b0;
    endtask

    task automatic check_read(input string nm, input logic [31:0] a,
                              input int len, input int sz, input int bu);
        logic [63:0] exp;
        n_checks++;
        if (rq_d.size() != len + 1) begin
            n_fail++;
            $display("FAIL %s_count: got %0d beats want %0d",
                     nm, rq_d.size(), len + 1);
        end
        for (int k = 0; k < rq_d.size() && k <= len; k++) begin
            exp = model_rd(beat_word(a, len, sz, bu, k));
            n_checks++;
            if (rq_d[k] !== exp || rq_l[k] !== (k == len)) begin
                n_fail++;
                $display("FAIL %s_beat%0d: got %h/%b want %h/%b",
                         nm, k, rq_d[k], rq_l[k], exp, k == len);
            end
        end
    endtask

    task automatic test_reset();
        i_awvalid = 1'b1; i_arvalid = 1'b1; i_wvalid = 1'b1;
        #2 rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({o_awready, o_arready, o_wready, o_bvalid, o_rvalid, o_rlast}
            !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b want 000000",
                     {o_awready, o_arready, o_wready,
                      o_bvalid, o_rvalid, o_rlast});
        end
        n_checks++;
        if ({o_bresp, o_rresp, o_bid, o_rid} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_ids: got %h want 0",
                     {o_bresp, o_rresp, o_bid, o_rid});
        end
        n_checks++;
        if (o_rdata !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h want 0", o_rdata);
        end
        i_awvalid = 1'b0; i_arvalid = 1'b0; i_wvalid = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        logic [63:0] dq [$];
        logic [1:0]  resp;
        logic [5:0]  bid;
        int          w, wb;
        send_aw(6'd5, 32'h100, 0, 3, 1, w);
        dq = {64'h1122334455667788};
        send_w(32'h100, 0, 3, 1, dq, 8'hFF, 0, w);
        get_b(bid, resp, wb);
        n_checks++;
        if (resp !== 2'b00 || bid !== 6'd5 || wb != 0) begin
            n_fail++;
            $display("FAIL single_b: got resp %b id %0d wait %0d want 00 5 0",
                     resp, bid, wb);
        end
        send_ar(6'd7, 32'h100, 0, 3, 1, w);
        get_r(1, 1'b0);
        check_read("single_rd", 32'h100, 0, 3, 1);
        n_checks++;
        if (rq_d.size() != 1 || rq_d[0] !== 64'h1122334455667788) begin
            n_fail++;
            $display("FAIL single_data: got %h want 1122334455667788",
                     rq_d.size() ? rq_d[0] : 64'h0);
        end
        n_checks++;
        if (r_first != 1 || r_id !== 6'd7 || r_resp !== 2'b00) begin
            n_fail++;
            $display("FAIL single_r: got lat %0d id %0d resp %b want 1 7 00",
                     r_first, r_id, r_resp);
        end
        send_ar(6'd8, 32'h10100, 0, 3, 1, w);
        get_r(1, 1'b0);
        check_read("alias_rd", 32'h10100, 0, 3, 1);
    endtask

    task automatic test_incr_burst();
        logic [63:0] dq [$];
        logic [1:0]  resp;
        logic [5:0]  bid;
        int          w;
        dq = {64'd1, 64'd2, 64'd3, 64'd4};
        write_burst(6'd3, 32'h200, 3, 3, 1, dq, 8'hFF, 3, resp, bid, w);
        n_checks++;
        if (w != 0 || resp !== 2'b00) begin
            n_fail++;
            $display("FAIL incr_wr: got waits %0d resp %b want 0 00", w, resp);
        end
        send_ar(6'd4, 32'h200, 3, 3, 1, w);
        get_r(4, 1'b0);
        check_read("incr_rd", 32'h200, 3, 3, 1);
        for (int k = 0; k < rq_d.size(); k++) begin
            n_checks++;
            if (rq_d[k] !== 64'(k + 1)) begin
                n_fail++;
                $display("FAIL incr_val%0d: got %h want %0d", k, rq_d[k], k + 1);
            end
        end
        send_ar(6'd4, 32'h200, 3, 3, 1, w);
        get_r(4, 1'b1);
        check_read("incr_stall", 32'h200, 3, 3, 1);
        n_checks++;
        if (r_holdbad != 0) begin
            n_fail++;
            $display("FAIL incr_hold: got %0d unstable stalls want 0",
                     r_holdbad);
        end
        @(negedge clk);
        n_checks++;
        if (o_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL incr_extra: got rvalid %b want 0", o_rvalid);
        end
        @(posedge clk); #1;
        send_ar(6'd2, 32'h200, 3, 2, 1, w);
        get_r(4, 1'b0);
        check_read("narrow_rd", 32'h200, 3, 2, 1);
    endtask

    task automatic test_wrap();
        logic [63:0] dq [$];
        logic [1:0]  resp;
        logic [5:0]  bid;
        int          w;
        dq = {{$urandom, $urandom}, {$urandom, $urandom},
              {$urandom, $urandom}, {$urandom, $urandom}};
        write_burst(6'd1, 32'h300, 3, 3, 1, dq, 8'hFF, 3, resp, bid, w);
        send_ar(6'd9, 32'h318, 3, 3, 2, w);
        get_r(4, 1'b0);
        check_read("wrap_rd", 32'h318, 3, 3, 2);
        n_checks++;
        if (rq_d.size() != 4 || rq_d[0] !== dq[3] || rq_d[1] !== dq[0]) begin
            n_fail++;
            $display("FAIL wrap_order: got %h %h want %h %h",
                     rq_d[0], rq_d[1], dq[3], dq[0]);
        end
    endtask

    task automatic test_strobe();
        logic [63:0] dq [$];
        logic [1:0]  resp;
        logic [5:0]  bid;
        int          w;
        dq = {64'h0};
        write_burst(6'd2, 32'h400, 0, 3, 1, dq, 8'hFF, 0, resp, bid, w);
        dq = {64'hFFFF_FFFF_FFFF_FFFF};
        write_burst(6'd2, 32'h400, 0, 3, 1, dq, 8'h0F, 0, resp, bid, w);
        send_ar(6'd2, 32'h400, 0, 3, 1, w);
        get_r(1, 1'b0);
        n_checks++;
        if (rq_d.size() != 1 || rq_d[0] !== 64'h0000_0000_FFFF_FFFF) begin
            n_fail++;
            $display("FAIL strobe_merge: got %h want 00000000ffffffff",
                     rq_d.size() ? rq_d[0] : 64'h0);
        end
    endtask

    task automatic test_arbitration();
        logic [63:0] dq [$];
        logic [1:0]  resp;
        logic [5:0]  bid;
        int          w;
        i_wvalid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (o_wready !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_wready: got %b want 0", o_wready);
        end
        @(posedge clk); #1;
        i_wvalid = 1'b0;
        dq = {64'hA5A5_0000_1234_5678};
        write_burst(6'd1, 32'h500, 0, 3, 1, dq, 8'hFF, 0, resp, bid, w);
        i_awid = 6'd10; i_awaddr = 32'h500; i_awlen = 8'd2;
        i_awsize = 3'd3; i_awburst = 2'd1; i_awvalid = 1'b1;
        i_arid = 6'd11; i_araddr = 32'h500; i_arlen = 8'd0;
        i_arsize = 3'd3; i_arburst = 2'd1; i_arvalid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (o_arready !== 1'b1 || o_awready !== 1'b0) begin
            n_fail++;
            $display("FAIL arb_first: got ar %b aw %b want 1 0",
                     o_arready, o_awready);
        end
        @(posedge clk); #1;
        i_arvalid = 1'b0;
        get_r(1, 1'b0);
        check_read("arb_rd1", 32'h500, 0, 3, 1);
        i_arid = 6'd12; i_arvalid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (o_awready !== 1'b1 || o_arready !== 1'b0) begin
            n_fail++;
            $display("FAIL arb_second: got aw %b ar %b want 1 0",
                     o_awready, o_arready);
        end
        @(posedge clk); #1;
        i_awvalid = 1'b0;
        dq = {{$urandom, $urandom}, {$urandom, $urandom},
              {$urandom, $urandom}};
        send_w(32'h500, 2, 3, 1, dq, 8'hFF, 1, w);
        get_b(bid, resp, w);
        n_checks++;
        if (resp !== 2'b10 || bid !== 6'd10) begin
            n_fail++;
            $display("FAIL early_wlast: got resp %b id %0d want 10 10",
                     resp, bid);
        end
        send_ar(6'd12, 32'h500, 0, 3, 1, w);
        get_r(1, 1'b0);
        check_read("arb_rd2", 32'h500, 0, 3, 1);
        dq = {64'd7, 64'd8};
        write_burst(6'd13, 32'h520, 1, 3, 1, dq, 8'hFF, -1, resp, bid, w);
        n_checks++;
        if (resp !== 2'b10) begin
            n_fail++;
            $display("FAIL missing_wlast: got %b want 10", resp);
        end
        write_burst(6'd14, 32'h520, 1, 3, 1, dq, 8'hFF, 1, resp, bid, w);
        n_checks++;
        if (resp !== 2'b00 || bid !== 6'd14) begin
            n_fail++;
            $display("FAIL clean_after_err: got %b id %0d want 00 14",
                     resp, bid);
        end
    endtask

    task automatic test_random();
        logic [63:0] dq [$];
        logic [31:0] a;
        logic [1:0]  resp;
        logic [5:0]  bid;
        logic [7:0]  strb;
        int          bu, len, w;
        for (int it = 0; it < 8; it++) begin
            bu = $urandom_range(0, 2);
            len = (bu == 2) ? (1 << $urandom_range(1, 3)) - 1
                            : $urandom_range(0, 7);
            a = 32'($urandom_range(32'h80, 32'h1FFF)) << 3;
            dq.delete();
            for (int k = 0; k <= len; k++) dq.push_back({$urandom, $urandom});
            write_burst(6'(it), a, len, 3, bu, dq, 8'hFF, len, resp, bid, w);
            dq.delete();
            for (int k = 0; k <= len; k++) dq.push_back({$urandom, $urandom});
            strb = 8'($urandom);
            write_burst(6'(it), a, len, 3, bu, dq, strb, len, resp, bid, w);
            n_checks++;
            if (resp !== 2'b00 || bid !== 6'(it)) begin
                n_fail++;
                $display("FAIL rand_b%0d: got %b id %0d want 00 %0d",
                         it, resp, bid, it);
            end
            send_ar(6'(it + 32), a, len, 3, bu, w);
            get_r(len + 1, 1'b1);
            check_read("rand_rd", a, len, 3, bu);
            n_checks++;
            if (r_holdbad != 0 || r_id !== 6'(it + 32)) begin
                n_fail++;
                $display("FAIL rand_r%0d: got hold %0d id %0d want 0 %0d",
                         it, r_holdbad, r_id, it + 32);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [63:0] dq [$];
        logic [1:0]  resp;
        logic [5:0]  bid;
        int          w, beats, cyc;
        for (int k = 0; k < 8; k++) dq.push_back({$urandom, $urandom});
        write_burst(6'd6, 32'h600, 7, 3, 1, dq, 8'hFF, 7, resp, bid, w);
        send_ar(6'd20, 32'h600, 7, 3, 1, w);
        i_rready = 1'b1;
        beats = 0; cyc = 0;
        while (cyc < 50) begin
            @(negedge clk);
            if (o_rvalid) beats++;
            if (beats == 3) break;
            @(posedge clk); #1;
            cyc++;
        end
        n_checks++;
        if (beats != 3) begin
            n_fail++;
            $display("FAIL mid_reach: got %0d beats want 3", beats);
        end
        rstn = 1'b0; i_rready = 1'b0;
        #1;
        n_checks++;
        if ({o_rvalid, o_rlast, o_bvalid, o_wready} !== 4'b0 ||
            o_rdata !== 64'h0 || o_rid !== 6'h0) begin
            n_fail++;
            $display("FAIL mid_reset: got v%b l%b data %h id %0d want 0",
                     o_rvalid, o_rlast, o_rdata, o_rid);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        send_ar(6'd21, 32'h600, 7, 3, 1, w);
        n_checks++;
        if (w != 1) begin
            n_fail++;
            $display("FAIL post_reset_arready: got %0d waits want 1", w);
        end
        get_r(8, 1'b0);
        check_read("post_reset_rd", 32'h600, 7, 3, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_incr_burst();
        test_wrap();
        test_strobe();
        test_arbitration();
        test_random();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_ram_responder.md
# axi_ram_responder

AXI4 responder (subordinate) backed by a single-port, byte-writable synchronous RAM. It answers the 64-bit AXI initiator port the SweRVolf core uses for main memory. It is a drop-in on-chip replacement for the DDR2 controller path in simulation and in DDR-less builds. Reads and writes are serialized through one FSM, bursts are fully supported, and every response is OKAY except a detected WLAST violation.

## Interface
- ID_WIDTH, 6, width of AWID/ARID/BID/RID
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 64, data width; fixed at 64 (8 byte lanes)
- MEM_DEPTH, 8192, number of 64-bit words (64 KiB)
- clk  in  1  sole clock; all logic on rising edge
- rstn  in  1  asynchronous, active-low reset
- i_awid / i_awaddr / i_awlen / i_awsize / i_awburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  write address channel
- i_awvalid  in  1 ; o_awready  out  1
- i_wdata / i_wstrb / i_wlast  in  64/8/1 ; i_wvalid  in  1 ; o_wready  out  1
- o_bid / o_bresp  out  ID_WIDTH/2 ; o_bvalid  out  1 ; i_bready  in  1
- i_arid / i_araddr / i_arlen / i_arsize / i_arburst  in  same widths as AW ; i_arvalid  in  1 ; o_arready  out  1
- o_rid / o_rdata / o_rresp / o_rlast  out  ID_WIDTH/64/2/1 ; o_rvalid  out  1 ; i_rready  in  1

## Operation
- FSM states: IDLE, WRITE, WRESP, READ.
- Register `active` clears on reset and sets on the first clk edge after rstn deasserts. o_awready and o_arready are 0 until `active` is set.
- IDLE arbitration:
  - o_awready = active & awvalid & grant_w.
  - o_arready = active & arvalid & !grant_w.
  - grant_w = awvalid & (!arvalid | last_grant==READ).
  - last_grant resets to WRITE, so a simultaneous first request goes to the read.
- Address capture on handshake: ID, addr, len, size, burst, and beat counter = 0.
- Word index = addr[$clog2(MEM_DEPTH)+2:3]. Higher address bits are ignored, so addresses alias.
- Next address per beat:
  - FIXED: unchanged.
  - INCR (and reserved 2'b11): addr + (1<<size).
  - WRAP: the bits below log2((len+1)<<size) increment modulo that container; upper bits are held.
- WRITE:
  - o_wready=1.
  - Each W handshake writes the bytes enabled by wstrb at the current word.
  - On the beat where the counter == len, go to WRESP.
  - Error flag sets if wlast=1 on a non-final beat, or wlast=0 on the final beat.
- WRESP:
  - o_bvalid=1, o_bid=captured ID.
  - o_bresp = 2'b10 (SLVERR) if the error flag is set, else 2'b00.
  - Hold until bready, then go to IDLE.
- READ:
  - A RAM read is issued when beats remain and (!rvalid | rready).
  - o_rvalid registers the issue. o_rdata is the RAM output, which is stable while stalled.
  - o_rlast=1 on beat len. o_rresp=2'b00. o_rid=captured ID.
  - After the rlast handshake, go to IDLE.
- Narrow reads return the full 64-bit word.
- The RAM has no reset; contents survive rstn.

## Timing
- Reset values: awready, arready, wready, bvalid, rvalid, rlast = 0; bresp, rresp = 0; bid, rid, rdata = 0 (rdata registered 0 until the first read).
- Write path:
  - AW handshake at edge E: wready high in the cycle after E.
  - W throughput is 1 beat/cycle.
  - Final W at edge F: bvalid high after F.
  - bready at edge G: state is IDLE after G; the next AW/AR can be accepted in the cycle after G.
- Read path:
  - AR handshake at edge E: first RAM read at E+1, rvalid high after E+1.
  - Throughput is 1 beat/cycle while rready=1.
  - rready low: rvalid, rdata, rlast held unchanged; no further RAM read is issued.
- No AW/AR is accepted outside IDLE. W beats arriving in IDLE are stalled (wready=0).
- Reset mid-burst: outputs return to their reset values immediately; the burst is abandoned and no B/R beat is completed.

## Test plan
- Reset, then AW+W (id 5, addr 0x100, len 0, strb 0xFF, data 0x1122334455667788): bresp=00, bid=5 one cycle after W. Then AR (addr 0x100): rdata 0x1122334455667788, rlast=1, rvalid two cycles after AR.
- INCR write, len 3, addr 0x200, data k+1 for beats k=0..3: 4 consecutive wready cycles. INCR read back returns 1,2,3,4 with rlast on beat 3. Random rready stalls: data held stable, no beat lost.
- WRAP read, len 3, size 3, addr 0x318 over words 0x300..0x318 holding A,B,C,D: returns D,A,B,C.
- Strobe merge: write 0xFFFF... with strb 0x0F onto a word holding 0: readback 0x00000000FFFFFFFF.
- AW and AR valid in the same cycle, twice: the read wins first, then the write. wlast asserted on beat 1 of a len-2 write: bresp=10.
- Assert rstn low during beat 2 of a len-7 read: rvalid drops immediately. After release, arready stays 0 for one cycle, then a new read completes correctly.
